// File: rtl/timer0_irq_pkg.sv
// Shared definitions for the TIMER0 interrupt controller: FSM state
// encoding, latched-source encoding, TIFR/TIMSK bit positions and the
// default vector word addresses.
package timer0_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Which flag the current request serves.
    typedef enum logic {
        SRC_TOV0 = 1'b0,
        SRC_OCF0 = 1'b1
    } src_e;

    // TIFR flag bit positions.
    localparam int OCF0_BIT  = 1;
    localparam int TOV0_BIT  = 0;
    // TIMSK enable bit positions.
    localparam int OCIE0_BIT = 1;
    localparam int TOIE0_BIT = 0;

    localparam logic [15:0] DEF_COMP_VECTOR = 16'h0026;
    localparam logic [15:0] DEF_OVF_VECTOR  = 16'h0028;

    // One-hot TIFR clear mask for a given source.
    function automatic logic [7:0] src_clear_mask(input src_e src);
        return (src == SRC_OCF0) ? 8'h02 : 8'h01;
    endfunction

endpackage

// File: rtl/timer0_irq_priority.sv
// Fixed-priority source select for the two TIMER0 flags.
// pending[1] is OCF0 (compare match) and wins over pending[0] (TOV0).
module timer0_irq_priority
    import timer0_irq_pkg::*;
(
    input  logic [1:0] pending_i,
    output logic       valid_o,
    output src_e       src_o
);

    // Compare match beats overflow when both are pending.
    always_comb begin
        valid_o = |pending_i;
        src_o   = pending_i[1] ? SRC_OCF0 : SRC_TOV0;
    end

endmodule

// File: rtl/timer0_irq_controller.sv
// TIMER0 interrupt controller: IDLE -> REQ -> CLEAR request/acknowledge
// sequencer with a one-cycle TIFR clear strobe. All outputs are registered
// from the next-state decode so they change together with the state.
// Optional feature: define TIMER0_IRQ_TIMEOUT_EN to abandon a request that
// is not acknowledged within ACK_TIMEOUT REQ cycles (pulses irq_timeout).
//
// Handshake: irq_req stays high with a stable irq_vector while in REQ; an
// irq_ack sampled high on a clock edge in REQ completes the transfer (and
// wins over a simultaneous withdraw); irq_ack sampled outside REQ is ignored.
module timer0_irq_controller
    import timer0_irq_pkg::*;
#(
    parameter logic [15:0] COMP_VECTOR = DEF_COMP_VECTOR,
    parameter logic [15:0] OVF_VECTOR  = DEF_OVF_VECTOR,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        sysClock,
    input  logic        rst,
    input  logic [7:0]  TIFR_in,
    input  logic [7:0]  TIMSK_in,
    input  logic        global_int_enable,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [15:0] irq_vector,
    output logic [7:0]  TIFR_clear_data,
    output logic        TIFR_clear_enable,
    output logic        busy,
    output logic        irq_timeout,
    output logic [1:0]  state_dbg_o
);

    state_e      state_q, state_d;
    src_e        src_q, src_d;
    logic        irq_req_q, irq_req_d;
    logic [15:0] vector_q, vector_d;
    logic [7:0]  clr_data_q, clr_data_d;
    logic        clr_en_q, clr_en_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;

    logic [1:0]  pending;
    logic        pr_valid;
    src_e        pr_src;
    logic        src_pending;
    logic        timeout_hit;

    // Bits 7:2 of TIFR/TIMSK belong to other timers.
    logic unused_reg_bits;
    assign unused_reg_bits = ^{TIFR_in[7:2], TIMSK_in[7:2]};

    assign pending = {TIFR_in[OCF0_BIT] & TIMSK_in[OCIE0_BIT],
                      TIFR_in[TOV0_BIT] & TIMSK_in[TOIE0_BIT]};

    timer0_irq_priority u_priority (
        .pending_i (pending),
        .valid_o   (pr_valid),
        .src_o     (pr_src)
    );

    // Is the source latched for the current request still asking?
    assign src_pending = (src_q == SRC_OCF0) ? pending[1] : pending[0];

`ifdef TIMER0_IRQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    // Count consecutive REQ cycles; cleared whenever REQ is left.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_REQ && state_d == ST_REQ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Acknowledge-wait counter register.
    always_ff @(posedge sysClock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (ACK_TIMEOUT == 0);
    assign timeout_hit        = 1'b0;
`endif

    // Next-state decode plus next values of every registered output.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (global_int_enable && pr_valid) begin
                    state_d = ST_REQ;
                    src_d   = pr_src;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_CLEAR;
                end else if (!src_pending || !global_int_enable) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        irq_req_d  = (state_d == ST_REQ);
        vector_d   = 16'h0000;
        if (irq_req_d) begin
            vector_d = (src_d == SRC_OCF0) ? COMP_VECTOR : OVF_VECTOR;
        end
        clr_en_d   = (state_d == ST_CLEAR);
        clr_data_d = clr_en_d ? src_clear_mask(src_d) : 8'h00;
        busy_d     = (state_d != ST_IDLE);
    end

    // State, latched source and output registers.
    always_ff @(posedge sysClock or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_TOV0;
            irq_req_q  <= 1'b0;
            vector_q   <= 16'h0000;
            clr_data_q <= 8'h00;
            clr_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            irq_req_q  <= irq_req_d;
            vector_q   <= vector_d;
            clr_data_q <= clr_data_d;
            clr_en_q   <= clr_en_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign irq_req           = irq_req_q;
    assign irq_vector        = vector_q;
    assign TIFR_clear_data   = clr_data_q;
    assign TIFR_clear_enable = clr_en_q;
    assign busy              = busy_q;
    assign irq_timeout       = timeout_q;
    assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_timer0_irq_controller.sv
// Directed bench for timer0_irq_controller. Inputs are driven 1 ns after a
// rising edge and first sampled by the following edge; outputs are checked
// 1 ns after that edge.
module tb_timer0_irq_controller;

    logic        sysClock = 1'b0;
    logic        rst;
    logic [7:0]  TIFR_in;
    logic [7:0]  TIMSK_in;
    logic        global_int_enable;
    logic        irq_ack;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic [7:0]  TIFR_clear_data;
    logic        TIFR_clear_enable;
    logic        busy;
    logic        irq_timeout;
    logic [1:0]  state_dbg_o;

    int n_tests = 0;
    int n_fail  = 0;

    timer0_irq_controller dut (
        .sysClock          (sysClock),
        .rst               (rst),
        .TIFR_in           (TIFR_in),
        .TIMSK_in          (TIMSK_in),
        .global_int_enable (global_int_enable),
        .irq_ack           (irq_ack),
        .irq_req           (irq_req),
        .irq_vector        (irq_vector),
        .TIFR_clear_data   (TIFR_clear_data),
        .TIFR_clear_enable (TIFR_clear_enable),
        .busy              (busy),
        .irq_timeout       (irq_timeout),
        .state_dbg_o       (state_dbg_o)
    );

    // Clock / reset
    always #5 sysClock = ~sysClock;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge sysClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},  16'(irq_req), 16'h0);
        check({tag, "_vec"},  irq_vector, 16'h0);
        check({tag, "_clen"}, 16'(TIFR_clear_enable), 16'h0);
        check({tag, "_clda"}, 16'(TIFR_clear_data), 16'h0);
        check({tag, "_busy"}, 16'(busy), 16'h0);
        check({tag, "_tmo"},  16'(irq_timeout), 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        TIFR_in = 8'h00;
        TIMSK_in = 8'h00;
        global_int_enable = 1'b0;
        irq_ack = 1'b0;

        // Reset state
        #12;
        check_all_zero("reset");
        check("reset_state", 16'(state_dbg_o), 16'h0);
        @(posedge sysClock); #1;
        rst = 1'b0;
        step();
        check_all_zero("post_reset_idle");

        // Overflow request, ack, clear strobe
        TIMSK_in = 8'h01; global_int_enable = 1'b1; TIFR_in = 8'h01;
        step();
        check("ovf_req", 16'(irq_req), 16'h1);
        check("ovf_vec", irq_vector, 16'h0028);
        check("ovf_busy", 16'(busy), 16'h1);
        check("ovf_state", 16'(state_dbg_o), 16'h1);
        check("ovf_noclr", 16'(TIFR_clear_enable), 16'h0);
        step();
        check("ovf_vec_hold", irq_vector, 16'h0028);
        irq_ack = 1'b1;
        step();
        check("ovf_clen", 16'(TIFR_clear_enable), 16'h1);
        check("ovf_clda", 16'(TIFR_clear_data), 16'h01);
        check("ovf_req_drop", 16'(irq_req), 16'h0);
        check("ovf_vec_zero", irq_vector, 16'h0);
        irq_ack = 1'b0; TIFR_in = 8'h00;
        step();
        check("ovf_clen_one_cycle", 16'(TIFR_clear_enable), 16'h0);
        check("ovf_clda_zero", 16'(TIFR_clear_data), 16'h00);
        check("ovf_idle", 16'(busy), 16'h0);

        // Both flags: OCF0 first, TOV0 at M+3
        TIMSK_in = 8'h03; TIFR_in = 8'h03;
        step();
        check("both_first_vec", irq_vector, 16'h0026);
        irq_ack = 1'b1;                 // edge M
        step();                         // M+1
        check("both_clda_ocf", 16'(TIFR_clear_data), 16'h02);
        check("both_clen", 16'(TIFR_clear_enable), 16'h1);
        irq_ack = 1'b0; TIFR_in = 8'h01;
        step();                         // M+2
        check("both_idle_req", 16'(irq_req), 16'h0);
        check("both_idle_busy", 16'(busy), 16'h0);
        step();                         // M+3
        check("both_second_req", 16'(irq_req), 16'h1);
        check("both_second_vec", irq_vector, 16'h0028);
        irq_ack = 1'b1;
        step();
        check("both_clda_tov", 16'(TIFR_clear_data), 16'h01);
        irq_ack = 1'b0; TIFR_in = 8'h00;
        step();
        check("both_done", 16'(busy), 16'h0);

        // Withdraw when flag disappears
        TIMSK_in = 8'h01; TIFR_in = 8'h01;
        step();
        check("wd_req", 16'(irq_req), 16'h1);
        TIFR_in = 8'h00;
        step();
        check("wd_req_drop", 16'(irq_req), 16'h0);
        check("wd_noclr", 16'(TIFR_clear_enable), 16'h0);
        check("wd_idle", 16'(busy), 16'h0);
        step();
        check("wd_noclr_late", 16'(TIFR_clear_enable), 16'h0);

        // Ack outside REQ is ignored
        irq_ack = 1'b1;
        step();
        check("stray_ack_busy", 16'(busy), 16'h0);
        check("stray_ack_clen", 16'(TIFR_clear_enable), 16'h0);
        irq_ack = 1'b0;

        // Global enable gating and withdraw on I=0
        global_int_enable = 1'b0; TIMSK_in = 8'h03; TIFR_in = 8'h03;
        step();
        step();
        check("gie_off_req", 16'(irq_req), 16'h0);
        global_int_enable = 1'b1;
        step();
        check("gie_on_req", 16'(irq_req), 16'h1);
        check("gie_on_vec", irq_vector, 16'h0026);
        global_int_enable = 1'b0;
        step();
        check("gie_wd_req", 16'(irq_req), 16'h0);
        check("gie_wd_noclr", 16'(TIFR_clear_enable), 16'h0);

        // Ack beats simultaneous withdraw
        global_int_enable = 1'b1;
        step();
        check("prio_req", 16'(irq_req), 16'h1);
        irq_ack = 1'b1; TIFR_in = 8'h00;
        step();
        check("prio_clen", 16'(TIFR_clear_enable), 16'h1);
        check("prio_clda", 16'(TIFR_clear_data), 16'h02);
        irq_ack = 1'b0;
        step();
        check("prio_idle", 16'(busy), 16'h0);

        // Asynchronous reset in REQ, then re-request
        TIMSK_in = 8'h01; TIFR_in = 8'h01;
        step();
        check("rst_req_pre", 16'(irq_req), 16'h1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_in_req");
        @(posedge sysClock); #1;
        rst = 1'b0;
        step();
        check("rst_rereq", 16'(irq_req), 16'h1);
        check("rst_rereq_vec", irq_vector, 16'h0028);

        // Asynchronous reset in CLEAR aborts the strobe
        irq_ack = 1'b1;
        step();
        check("rst_clr_pre", 16'(TIFR_clear_enable), 16'h1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_in_clear");
        @(posedge sysClock); #1;
        rst = 1'b0; irq_ack = 1'b0;
        step();
        check("rst_clr_rereq", 16'(irq_req), 16'h1);

        // Long wait in REQ without ack
        begin
            logic saw_clear;
            saw_clear = 1'b0;
            for (int i = 0; i < 15; i++) begin
                step();
                if (TIFR_clear_enable || irq_timeout) saw_clear = 1'b1;
            end
            check("wait15_req", 16'(irq_req), 16'h1);
            check("wait15_quiet", 16'(saw_clear), 16'h0);
            step();
`ifdef TIMER0_IRQ_TIMEOUT_EN
            check("tmo_pulse", 16'(irq_timeout), 16'h1);
            check("tmo_req_drop", 16'(irq_req), 16'h0);
            check("tmo_noclr", 16'(TIFR_clear_enable), 16'h0);
            step();
            check("tmo_pulse_end", 16'(irq_timeout), 16'h0);
            check("tmo_rereq", 16'(irq_req), 16'h1);
`else
            check("no_tmo_pulse", 16'(irq_timeout), 16'h0);
            check("no_tmo_req", 16'(irq_req), 16'h1);
            for (int i = 0; i < 10; i++) step();
            check("no_tmo_req_late", 16'(irq_req), 16'h1);
            check("no_tmo_vec_late", irq_vector, 16'h0028);
`endif
        end
        TIFR_in = 8'h00;
        step();
        step();
        check("final_idle", 16'(busy), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
